// File: rtl/mux_nx1_scan.sv
// N-channel registered mux with manual select and auto-scan (per-channel dwell).
// Optional build macro MUX_CHANNEL_MASK_EN adds a chan_mask input that skips disabled channels.

// Per-channel gate: passes its channel only when the select points at it.
module mux_nx1_scan_lane #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  assign data_o = (sel_i == SEL_W'(IDX)) ? data_i : '0;
endmodule

module mux_nx1_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      load,
  input  logic [SEL_W-1:0]          sel_in,
`ifdef MUX_CHANNEL_MASK_EN
  input  logic [CHANNELS-1:0]       chan_mask,
`endif
  output logic [WIDTH-1:0]          mux_out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      valid,
  output logic                      wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN} state_e;

  state_e                           state_q, state_d;
  logic [SEL_W-1:0]                 sel_q, sel_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [WIDTH-1:0]                 out_q, out_d;
  logic                             valid_q, valid_d;
  logic                             wrap_q, wrap_d;

  logic [CHANNELS-1:0]              mask_w;
  logic [CHANNELS-1:0][WIDTH-1:0]   ch;
  logic [CHANNELS-1:0][WIDTH-1:0]   lane_out;
  logic [WIDTH-1:0]                 pick;
  logic                             load_ok, any_en, upd_out;
  logic                             hi_found, adv_wrap;
  logic [SEL_W-1:0]                 hi_sel, lo_sel, adv_sel;

`ifdef MUX_CHANNEL_MASK_EN
  assign mask_w = chan_mask;
`else
  assign mask_w = '1;
`endif

  assign ch     = in_bus;
  assign any_en = |mask_w;

  // A load counts only if it names an existing, enabled channel.
  always_comb begin
    load_ok = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (load && (sel_in == SEL_W'(i)) && mask_w[i]) load_ok = 1'b1;
  end

  // Circular search for the next enabled channel after sel_q; descending scan
  // leaves the lowest qualifying index in hi_sel / lo_sel.
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = sel_q;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (mask_w[i]) begin
        lo_sel = SEL_W'(i);
        if (SEL_W'(i) > sel_q) begin
          hi_sel   = SEL_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    adv_sel  = hi_found ? hi_sel : lo_sel;
    adv_wrap = !hi_found;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: mode of operation follows en/mode sampled at each edge
  always_comb begin
    if (!en)       state_d = S_IDLE;
    else if (!mode) state_d = S_MANUAL;
    else           state_d = S_SCAN;
  end

  // Output / datapath next-state; counter is zero whenever we are not scanning,
  // which also gives a fresh dwell on every entry into SCAN.
  always_comb begin
    sel_d   = sel_q;
    cnt_d   = '0;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    upd_out = 1'b0;
    unique case (state_d)
      S_MANUAL: begin
        if (load_ok) sel_d = sel_in;
        valid_d = 1'b1;
        upd_out = 1'b1;
      end
      S_SCAN: begin
        if (!any_en) begin
          sel_d = sel_q;
        end else if (load_ok) begin
          sel_d   = sel_in;
          valid_d = 1'b1;
          upd_out = 1'b1;
        end else if (state_q != S_SCAN) begin
          valid_d = 1'b1;
          upd_out = 1'b1;
        end else if (cnt_q == CNT_W'(DWELL-1)) begin
          sel_d   = adv_sel;
          wrap_d  = adv_wrap;
          valid_d = 1'b1;
          upd_out = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          valid_d = 1'b1;
          upd_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    mux_nx1_scan_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(g)) u_lane (
      .sel_i  (sel_d),
      .data_i (ch[g]),
      .data_o (lane_out[g])
    );
  end

  always_comb begin
    pick = '0;
    for (int i = 0; i < CHANNELS; i++) pick = pick | lane_out[i];
  end

  assign out_d = upd_out ? pick : out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign mux_out = out_q;
  assign cur_sel = sel_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: directed scenarios plus random traffic against a
// cycle-level behavioural model tracking how long each channel has been shown.
module tb_mux_nx1_scan;
  localparam int W  = 4;
  localparam int CH = 4;
  localparam int SW = 2;
  localparam int DW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, mode, load;
  logic [SW-1:0]     sel_in;
  logic [CH*W-1:0]   in_bus;
  logic [W-1:0]      mux_out;
  logic [SW-1:0]     cur_sel;
  logic              valid, wrap;

  logic [3*W-1:0]    in_bus3;
  logic [W-1:0]      mux_out3;
  logic [SW-1:0]     cur_sel3;
  logic              valid3, wrap3;

  int errors = 0;
  int checks = 0;

  mux_nx1_scan #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .en(en), .mode(mode), .load(load),
    .sel_in(sel_in),
`ifdef MUX_CHANNEL_MASK_EN
    .chan_mask(4'b1111),
`endif
    .mux_out(mux_out), .cur_sel(cur_sel), .valid(valid), .wrap(wrap)
  );

  mux_nx1_scan #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW), .DWELL(DW)) dut3 (
    .clk(clk), .rst(rst), .in_bus(in_bus3), .en(en), .mode(mode), .load(load),
    .sel_in(sel_in),
`ifdef MUX_CHANNEL_MASK_EN
    .chan_mask(3'b111),
`endif
    .mux_out(mux_out3), .cur_sel(cur_sel3), .valid(valid3), .wrap(wrap3)
  );

  // Reference model: m_held = number of cycles the current channel has been shown in scan.
  logic [W-1:0]  m_out;
  logic [SW-1:0] m_sel;
  logic          m_valid, m_wrap, m_scan;
  int            m_held;

  task automatic tick();
    logic r, e, md, ld;
    logic [SW-1:0]   s;
    logic [CH*W-1:0] b;
    r = rst; e = en; md = mode; ld = load; s = sel_in; b = in_bus;
    @(posedge clk);
    #1;
    if (r) begin
      m_out = '0; m_sel = '0; m_valid = 1'b0; m_wrap = 1'b0; m_scan = 1'b0; m_held = 0;
    end else if (!e) begin
      m_valid = 1'b0; m_wrap = 1'b0; m_scan = 1'b0; m_held = 0;
    end else if (!md) begin
      if (ld && int'(s) < CH) m_sel = s;
      m_out = b[int'(m_sel)*W +: W];
      m_valid = 1'b1; m_wrap = 1'b0; m_scan = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (ld && int'(s) < CH) begin
        m_sel = s; m_held = 1;
      end else if (!m_scan) begin
        m_held = 1;
      end else if (m_held == DW) begin
        m_wrap = (int'(m_sel) == CH-1);
        m_sel  = SW'((int'(m_sel) + 1) % CH);
        m_held = 1;
      end else begin
        m_held++;
      end
      m_out = b[int'(m_sel)*W +: W];
      m_valid = 1'b1; m_scan = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel_in = '0;
    in_bus = {4'hD, 4'hC, 4'hB, 4'hA};
    in_bus3 = {4'hC, 4'hB, 4'hA};
    tick(); tick();
    checks++; if (mux_out !== 4'h0) begin errors++; $display("FAIL reset_mux_out: got %0h expected 0", mux_out); end
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL reset_cur_sel: got %0d expected 0", cur_sel); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    checks++; if (wrap3 !== 1'b0 || cur_sel3 !== 2'd0) begin errors++; $display("FAIL reset_dut3: got sel=%0d wrap=%0b expected 0/0", cur_sel3, wrap3); end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    en = 1'b1; mode = 1'b0; load = 1'b1; sel_in = 2'd2;
    tick();
    checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL manual_load_sel: got %0d expected 2", cur_sel); end
    checks++; if (mux_out !== 4'hC) begin errors++; $display("FAIL manual_load_out: got %0h expected c", mux_out); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL manual_valid: got %0b expected 1", valid); end
    load = 1'b0; in_bus[11:8] = 4'h5;
    tick();
    checks++; if (mux_out !== 4'h5) begin errors++; $display("FAIL manual_track: got %0h expected 5", mux_out); end
    load = 1'b1; sel_in = 2'd3;
    tick();
    checks++; if (mux_out !== 4'hD) begin errors++; $display("FAIL manual_load3_out: got %0h expected d", mux_out); end
    checks++; if (cur_sel !== 2'd3) begin errors++; $display("FAIL manual_load3_sel: got %0d expected 3", cur_sel); end
    checks++; if (cur_sel3 !== 2'd2) begin errors++; $display("FAIL manual_invalid_sel: got %0d expected 2", cur_sel3); end
    checks++; if (mux_out3 !== 4'hC || valid3 !== 1'b1) begin errors++; $display("FAIL manual_invalid_out: got %0h/%0b expected c/1", mux_out3, valid3); end
    load = 1'b0; in_bus[11:8] = 4'hC;
  endtask

  task automatic test_scan();
    logic [W-1:0] exp_seq [13];
    exp_seq = '{4'hA, 4'hA, 4'hA, 4'hB, 4'hB, 4'hB, 4'hC, 4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'hA};
    mode = 1'b0; load = 1'b1; sel_in = 2'd0;
    tick();
    load = 1'b0; mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++; if (mux_out !== exp_seq[i]) begin errors++; $display("FAIL scan_seq[%0d]: got %0h expected %0h", i, mux_out, exp_seq[i]); end
      checks++; if (wrap !== (i == 12)) begin errors++; $display("FAIL scan_wrap[%0d]: got %0b expected %0b", i, wrap, (i == 12)); end
    end
  endtask

  task automatic test_scan_jump();
    mode = 1'b0; load = 1'b1; sel_in = 2'd2;
    tick();
    mode = 1'b1; load = 1'b0;
    tick(); tick(); tick();
    load = 1'b1; sel_in = 2'd1;
    tick();
    load = 1'b0;
    checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL jump_sel: got %0d expected 1", cur_sel); end
    checks++; if (mux_out !== 4'hB || wrap !== 1'b0) begin errors++; $display("FAIL jump_out: got %0h/%0b expected b/0", mux_out, wrap); end
    tick();
    checks++; if (mux_out !== 4'hB) begin errors++; $display("FAIL jump_hold1: got %0h expected b", mux_out); end
    tick();
    checks++; if (mux_out !== 4'hB) begin errors++; $display("FAIL jump_hold2: got %0h expected b", mux_out); end
    tick();
    checks++; if (mux_out !== 4'hC || cur_sel !== 2'd2) begin errors++; $display("FAIL jump_advance: got %0h/%0d expected c/2", mux_out, cur_sel); end
  endtask

  task automatic test_enable_reset();
    tick();
    en = 1'b0;
    tick();
    checks++; if (mux_out !== 4'hC || cur_sel !== 2'd2) begin errors++; $display("FAIL disable_hold: got %0h/%0d expected c/2", mux_out, cur_sel); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL disable_valid: got %0b expected 0", valid); end
    tick();
    checks++; if (valid !== 1'b0 || mux_out !== 4'hC) begin errors++; $display("FAIL disable_hold2: got %0h/%0b expected c/0", mux_out, valid); end
    en = 1'b1;
    tick();
    checks++; if (valid !== 1'b1 || mux_out !== 4'hC) begin errors++; $display("FAIL reenable: got %0h/%0b expected c/1", mux_out, valid); end
    tick(); tick();
    checks++; if (mux_out !== 4'hC) begin errors++; $display("FAIL reenable_dwell: got %0h expected c", mux_out); end
    tick();
    checks++; if (mux_out !== 4'hD) begin errors++; $display("FAIL reenable_adv: got %0h expected d", mux_out); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (mux_out !== 4'h0 || cur_sel !== 2'd0) begin errors++; $display("FAIL mid_rst: got %0h/%0d expected 0/0", mux_out, cur_sel); end
    checks++; if (valid !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got %0b/%0b expected 0/0", valid, wrap); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rst    = ($urandom_range(0, 59) == 0);
      en     = ($urandom_range(0, 9) != 0);
      mode   = ($urandom_range(0, 3) != 0);
      load   = ($urandom_range(0, 7) == 0);
      sel_in = SW'($urandom);
      if ($urandom_range(0, 3) == 0) in_bus = (CH*W)'($urandom);
      tick();
      checks++; if (mux_out !== m_out) begin errors++; $display("FAIL rand_mux_out@%0d: got %0h expected %0h", n, mux_out, m_out); end
      checks++; if (cur_sel !== m_sel) begin errors++; $display("FAIL rand_cur_sel@%0d: got %0d expected %0d", n, cur_sel, m_sel); end
      checks++; if (valid !== m_valid) begin errors++; $display("FAIL rand_valid@%0d: got %0b expected %0b", n, valid, m_valid); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL rand_wrap@%0d: got %0b expected %0b", n, wrap, m_wrap); end
    end
  endtask

  initial begin
    m_out = '0; m_sel = '0; m_valid = 1'b0; m_wrap = 1'b0; m_scan = 1'b0; m_held = 0;
    test_reset();
    test_manual();
    test_scan();
    test_scan_jump();
    test_enable_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
